// File: rtl/port_bus_bridge.sv
// port_bus_bridge: byte-stream command frames to port_id/wen/ren peripheral bus cycles, one response byte per frame.
module port_bus_bridge #(
  parameter logic [7:0] OP_WRITE = 8'hA5,
  parameter logic [7:0] OP_READ  = 8'h5A,
  parameter logic [7:0] ACK      = 8'h06,
  parameter logic [7:0] NAK      = 8'h15,
  parameter int TO_WIDTH         = 16,
  parameter logic [TO_WIDTH-1:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] port_id_o,
  output logic [7:0] out_port_o,
  input  logic [7:0] in_port_i,
  output logic       wen_o,
  output logic       ren_o,
  output logic       busy_o
);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, SETUP, STROBE, RESP} state_t;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, port_id_q, port_id_d, out_port_q, out_port_d, rsp_q, rsp_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic hs, expire;
  assign cmd_ready_o = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign hs = cmd_valid_i && cmd_ready_o;
  assign expire = (TIMEOUT != '0) && (cnt_q == TO_LAST);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign wen_o = (state_q == STROBE) && is_wr_q;
  assign ren_o = (state_q == STROBE) && !is_wr_q;
  assign rsp_valid_o = state_q == RESP;
  assign busy_o = state_q != IDLE;
  assign rsp_data_o = rsp_q;
  assign port_id_o = port_id_q;
  assign out_port_o = out_port_q;
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d = addr_q;
    data_d = data_q;
    port_id_d = port_id_q;
    out_port_d = out_port_q;
    rsp_d = rsp_q;
    cnt_d = '0;
    case (state_q)
      IDLE: if (hs) begin
        is_wr_d = cmd_data_i == OP_WRITE;
        if (cmd_data_i == OP_WRITE || cmd_data_i == OP_READ) state_d = GET_ADDR;
        else begin
          state_d = RESP;
          rsp_d = NAK;
        end
      end
      // Bus address/data are loaded on entry to SETUP so they are visible during SETUP itself.
      GET_ADDR: if (hs) begin
        addr_d = cmd_data_i;
        state_d = is_wr_q ? GET_DATA : SETUP;
        port_id_d = is_wr_q ? port_id_q : cmd_data_i;
      end else if (expire) begin
        state_d = RESP;
        rsp_d = NAK;
      end else cnt_d = cnt_inc;
      GET_DATA: if (hs) begin
        data_d = cmd_data_i;
        port_id_d = addr_q;
        out_port_d = cmd_data_i;
        state_d = SETUP;
      end else if (expire) begin
        state_d = RESP;
        rsp_d = NAK;
      end else cnt_d = cnt_inc;
      SETUP: state_d = STROBE;
      STROBE: begin
        state_d = RESP;
        rsp_d = is_wr_q ? ACK : in_port_i;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      port_id_q <= '0;
      out_port_q <= '0;
      rsp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      port_id_q <= port_id_d;
      out_port_q <= out_port_d;
      rsp_q <= rsp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_port_bus_bridge.sv
// tb_port_bus_bridge: directed frames against port_bus_bridge with TIMEOUT=8 and hand-computed expectations.
module tb_port_bus_bridge;
  logic clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, wen, ren, busy;
  logic [7:0] cmd_data, rsp_data, port_id, out_port, in_port;
  int total = 0, bad = 0, wen_n = 0, ren_n = 0, both_n = 0;
  port_bus_bridge #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .port_id_o(port_id),
    .out_port_o(out_port), .in_port_i(in_port), .wen_o(wen), .ren_o(ren), .busy_o(busy)
  );
  assign in_port = 8'h5A ^ port_id;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wen) wen_n++;
    if (ren) ren_n++;
    if (wen && ren) both_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    logic ok = 0;
    cmd_data = b;
    cmd_valid = 1;
    while (!ok && n < 50) begin
      ok = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 0;
    check("send_hs", 32'(ok), 1);
  endtask
  initial begin
    int w0, r0, n;
    logic stable;
    rst_n = 0; cmd_valid = 0; cmd_data = 0; rsp_ready = 1;
    #1;
    check("rst_port_id", port_id, 0);
    check("rst_out_port", out_port, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_strobes", {wen, ren, rsp_valid, busy}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    step(); step();
    @(negedge clk) rst_n = 1;
    step();
    // write frame
    w0 = wen_n; r0 = ren_n;
    send(8'hA5); send(8'h10); send(8'h3C);
    check("wr_setup_id", port_id, 8'h10);
    check("wr_setup_out", out_port, 8'h3C);
    check("wr_setup_wen", {wen, ren, rsp_valid}, 0);
    step();
    check("wr_strobe", {wen, ren, rsp_valid}, 3'b100);
    check("wr_strobe_id", {port_id, out_port}, 16'h103C);
    step();
    check("wr_resp", {wen, rsp_valid, rsp_data}, {2'b01, 8'h06});
    step();
    check("wr_idle", {rsp_valid, busy, cmd_ready}, 3'b001);
    check("wr_pulses", {wen_n - w0, ren_n - r0}, {32'd1, 32'd0});
    // read frame
    w0 = wen_n; r0 = ren_n;
    send(8'h5A); send(8'h04);
    check("rd_setup_id", {port_id, wen, ren}, {8'h04, 2'b00});
    step();
    check("rd_strobe", {port_id, wen, ren}, {8'h04, 2'b01});
    step();
    check("rd_resp", {rsp_valid, rsp_data}, {1'b1, 8'h5E});
    step();
    check("rd_pulses", {wen_n - w0, ren_n - r0}, {32'd0, 32'd1});
    // bad opcode then a normal write
    w0 = wen_n; r0 = ren_n;
    send(8'h77);
    check("nak_resp", {rsp_valid, rsp_data}, {1'b1, 8'h15});
    step();
    check("nak_pulses", {wen_n - w0, ren_n - r0}, {32'd0, 32'd0});
    send(8'hA5); send(8'h20); send(8'h99);
    step(); step();
    check("after_nak_ack", {rsp_valid, rsp_data, port_id, out_port}, {1'b1, 8'h06, 8'h20, 8'h99});
    step();
    // timeout after address byte
    w0 = wen_n;
    send(8'hA5); send(8'h10);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("to_cycles", n, 8);
    check("to_nak", rsp_data, 8'h15);
    step();
    check("to_no_wen", wen_n - w0, 0);
    // seven idle cycles is just inside the window
    send(8'hA5); send(8'h10);
    repeat (7) step();
    send(8'h3C);
    step(); step();
    check("to7_ack", {rsp_valid, rsp_data}, {1'b1, 8'h06});
    step();
    check("to7_wen", wen_n - w0, 1);
    // response backpressure with a queued opcode
    rsp_ready = 0;
    send(8'hA5); send(8'h30); send(8'h44);
    step(); step();
    cmd_data = 8'h5A; cmd_valid = 1;
    stable = 1;
    repeat (20) begin
      if (!(rsp_valid && rsp_data == 8'h06 && !cmd_ready && busy)) stable = 0;
      step();
    end
    check("bp_stable", stable, 1);
    rsp_ready = 1;
    step();
    check("bp_release", {rsp_valid, busy, cmd_ready}, 3'b001);
    step();
    check("bp_opcode_taken", {busy, cmd_ready}, 2'b11);
    send(8'h08);
    step(); step();
    check("bp_read_resp", {rsp_valid, rsp_data}, {1'b1, 8'h52});
    step();
    // async reset during write strobe
    send(8'hA5); send(8'h50); send(8'h66);
    step();
    check("rs_strobe", {wen, port_id}, {1'b1, 8'h50});
    #2 rst_n = 0;
    #1;
    check("rs_drop", {wen, rsp_valid, port_id, busy}, 0);
    check("rs_cmd_ready", cmd_ready, 1);
    @(negedge clk) rst_n = 1;
    stable = 1;
    repeat (5) begin
      step();
      if (rsp_valid || busy || !cmd_ready) stable = 0;
    end
    check("rs_quiet", stable, 1);
    check("never_both", both_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
